str_reverser: RTL and testbench

Parametrised streaming sequence reverser: accepts a variable-length string of WIDTH-bit elements over a valid/ready input stream and returns it over a valid/ready output stream, either reversed or in original order. It is the successor to the fixed 16×8-bit parallel string reverser. It sits between byte-stream producers and consumers in the text-processing datapath and adds:

- variable string length;
- handshaking on both sides;
- a per-string mode.

---
 rtl/str_reverser_if.sv | 22 ++
 rtl/str_reverser.sv | 93 +++++++++
 tb/tb_str_reverser.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/str_reverser_if.sv
// str_reverser_if: valid/ready input and output element streams of the string reverser.
interface str_reverser_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/str_reverser.sv
// str_reverser: buffers one string of up to DEPTH elements and replays it reversed or in order.
// Optional macro STR_REV_OVF_EN: beats beyond DEPTH are dropped until in_last and an overflow flag is raised.
module str_reverser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  str_reverser_if.slave  s,
  output logic           busy,
  output logic           done
`ifdef STR_REV_OVF_EN
  ,
  output logic           overflow
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TOP = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {LOAD, EMIT, DROP} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] wr_cnt, rd_ptr, len;
  logic mode, mode_now, in_fire, out_fire, close, last_elem, fin;
  assign in_fire = s.in_valid && s.in_ready;
  assign out_fire = s.out_valid && s.out_ready;
  // mode is only taken from the first beat; later beats reuse the latched value
  assign mode_now = (wr_cnt == '0) ? s.in_mode : mode;
  assign close = state == LOAD && in_fire && (s.in_last || wr_cnt == TOP);
  // the len-th element is the lowest address when reversing, the highest when passing through
  assign last_elem = mode ? (rd_ptr == len - ONE) : (rd_ptr == '0);
  assign fin = state == EMIT && out_fire && last_elem;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else state <= state_nx;
  // next-state decode
  always_comb begin
    state_nx = state;
    if (close)
`ifdef STR_REV_OVF_EN
      state_nx = s.in_last ? EMIT : DROP;
`else
      state_nx = EMIT;
`endif
    else if (state == DROP && in_fire && s.in_last) state_nx = EMIT;
    else if (fin) state_nx = LOAD;
  end
  // stream outputs; out_data is an asynchronous read at the registered pointer
  always_comb begin
    s.in_ready = state != EMIT;
    s.out_valid = state == EMIT;
    s.out_last = state == EMIT && last_elem;
    s.out_data = mem[rd_ptr[AW-1:0]];
    busy = state != LOAD || wr_cnt != '0;
  end
  // write counter, length, mode latch, read pointer and done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
      len <= '0;
      mode <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (state == LOAD && in_fire) begin
        wr_cnt <= close ? '0 : wr_cnt + ONE;
        mode <= mode_now;
      end
      if (close) begin
        len <= wr_cnt + ONE;
        rd_ptr <= mode_now ? '0 : wr_cnt;
      end
      if (state == DROP && in_fire && s.in_last) begin
        len <= FULL;
        rd_ptr <= mode ? '0 : TOP;
      end
      if (state == EMIT && out_fire && !last_elem) rd_ptr <= mode ? rd_ptr + ONE : rd_ptr - ONE;
    end
  // element storage, written only while loading
  always_ff @(posedge clk)
    if (state == LOAD && in_fire) mem[wr_cnt[AW-1:0]] <= s.in_data;
`ifdef STR_REV_OVF_EN
  // overflow flag: set on entering DROP, cleared with the done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else if (close && !s.in_last) overflow <= 1'b1;
    else if (fin) overflow <= 1'b0;
`endif
endmodule

// File: tb/tb_str_reverser.sv
// tb_str_reverser: random and directed streams checked against a queue-based string model.
module tb_str_reverser;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  typedef struct packed {logic [WIDTH-1:0] d; logic l;} item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int pops = 0;
  int rdy_mode = 0;
  item_t exp_q[$];
  item_t got[$];
  logic [WIDTH-1:0] cur[$];
  bit cur_mode, dropping, done_exp;
`ifdef STR_REV_OVF_EN
  logic overflow;
  bit ovf_exp;
`endif
  str_reverser_if #(.WIDTH(WIDTH)) bus ();
  str_reverser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .s(bus),
    .busy(busy),
    .done(done)
`ifdef STR_REV_OVF_EN
    ,
    .overflow(overflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // a finished string is queued as its output sequence: reversed or in order, last flag on the final one
  function automatic void close_str();
    int n;
    n = cur.size();
    for (int i = 0; i < n; i++) exp_q.push_back(item_t'{cur[cur_mode ? i : n - 1 - i], i == n - 1});
    cur.delete();
  endfunction
  function automatic void model_in(input logic [WIDTH-1:0] d, input logic l, input logic m);
    if (dropping) begin
      if (l) begin
        dropping = 0;
        close_str();
      end
    end else begin
      if (cur.size() == 0) cur_mode = m;
      cur.push_back(d);
      if (l || cur.size() == DEPTH) begin
`ifdef STR_REV_OVF_EN
        if (!l) begin
          dropping = 1;
          ovf_exp = 1;
        end else close_str();
`else
        close_str();
`endif
      end
    end
  endfunction
  // compare process: inputs and outputs are stable at the falling edge and describe the coming transfer
  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      exp_q.delete();
      cur.delete();
      dropping = 0;
      done_exp = 0;
`ifdef STR_REV_OVF_EN
      ovf_exp = 0;
      chk("rst_overflow", overflow, 0);
`endif
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("in_ready", bus.in_ready, exp_q.size() == 0);
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      chk("done", done, done_exp);
      chk("busy", busy, exp_q.size() != 0 || cur.size() != 0 || dropping);
`ifdef STR_REV_OVF_EN
      chk("overflow", overflow, ovf_exp);
`endif
      if (done) done_cnt++;
      if (bus.out_valid && exp_q.size() != 0) begin
        chk("out_data", bus.out_data, exp_q[0].d);
        chk("out_last", bus.out_last, exp_q[0].l);
      end
      done_exp = 0;
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        it = exp_q.pop_front();
        got.push_back(item_t'{bus.out_data, bus.out_last});
        pops++;
        if (it.l) begin
          done_exp = 1;
`ifdef STR_REV_OVF_EN
          ovf_exp = 0;
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) model_in(bus.in_data, bus.in_last, bus.in_mode);
    end
  end
  // consumer: always ready, a 1,0,0,1 pattern, or random
  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(0, 1));
    end
  end
  task automatic beat(input logic [WIDTH-1:0] d, input logic l, input logic m);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    bus.in_mode = m;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL beat_wait: in_ready got 0 expected 1 within 300 cycles at %0t", $time);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = WIDTH'($urandom);
    bus.in_last = 1'($urandom);
    bus.in_mode = 1'($urandom);
  endtask
  task automatic send(input logic [WIDTH-1:0] v[$], input bit m, input bit flip, input bit gaps);
    for (int i = 0; i < v.size(); i++) begin
      beat(v[i], i == v.size() - 1, (i != 0 && flip) ? !m : m);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_wait: busy got 1 expected 0 within 1000 cycles at %0t", $time);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check_got(input string name, input logic [WIDTH-1:0] ev[$], input logic [31:0] lastmask);
    chk({name, "_count"}, got.size(), ev.size());
    for (int i = 0; i < ev.size() && i < got.size(); i++) begin
      chk({name, "_data"}, got[i].d, ev[i]);
      chk({name, "_last"}, got[i].l, lastmask[i]);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [WIDTH-1:0] v[$];
    logic [WIDTH-1:0] ev[$];
    int dc, base, t, n;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_mode = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // reverse, full length
    got.delete();
    dc = done_cnt;
    v.delete();
    ev.delete();
    for (int i = 0; i < 16; i++) begin
      v.push_back(8'(i));
      ev.push_back(8'(15 - i));
    end
    send(v, 0, 0, 0);
    wait_idle();
    check_got("full_rev", ev, 32'h0000_8000);
    chk("full_rev_done", done_cnt - dc, 1);
    chk("full_rev_in_ready", bus.in_ready, 1);
    // single element
    got.delete();
    dc = done_cnt;
    v = '{8'hA5};
    send(v, 0, 0, 0);
    wait_idle();
    check_got("single", v, 32'h1);
    chk("single_done", done_cnt - dc, 1);
    // pass-through with a mid-string mode change
    got.delete();
    v = '{8'h11, 8'h22, 8'h33};
    send(v, 1, 1, 0);
    wait_idle();
    check_got("pass", v, 32'h4);
    // backpressure on "ABCD"
    got.delete();
    rdy_mode = 1;
    v = '{8'h41, 8'h42, 8'h43, 8'h44};
    ev = '{8'h44, 8'h43, 8'h42, 8'h41};
    send(v, 0, 0, 0);
    wait_idle();
    check_got("bp", ev, 32'h8);
    rdy_mode = 0;
    // 20 beats against DEPTH 16
    got.delete();
    dc = done_cnt;
    v.delete();
    ev.delete();
    for (int i = 0; i < 20; i++) v.push_back(8'(i));
    for (int i = 0; i < 16; i++) ev.push_back(8'(15 - i));
    send(v, 0, 0, 0);
`ifdef STR_REV_OVF_EN
    chk("ovf_flag", overflow, 1);
    wait_idle();
    check_got("ovf", ev, 32'h0000_8000);
    chk("ovf_done", done_cnt - dc, 1);
    chk("ovf_clear", overflow, 0);
`else
    for (int i = 0; i < 4; i++) ev.push_back(8'(19 - i));
    wait_idle();
    check_got("ovf", ev, 32'h0008_8000);
    chk("ovf_done", done_cnt - dc, 2);
`endif
    // reset after 3 of 8 outputs
    got.delete();
    dc = done_cnt;
    base = pops;
    v.delete();
    for (int i = 0; i < 8; i++) v.push_back(8'(8'h30 + i));
    send(v, 0, 0, 0);
    t = 0;
    @(negedge clk);
    while (pops < base + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reached", pops - base, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt - dc, 0);
    chk("rst_mid_in_ready_after", bus.in_ready, 1);
    got.delete();
    v = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    ev = '{8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
    send(v, 0, 0, 0);
    wait_idle();
    check_got("after_rst", ev, 32'h10);
    // random strings, modes, gaps and backpressure
    rdy_mode = 2;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, DEPTH + 4);
      v.delete();
      for (int i = 0; i < n; i++) v.push_back(WIDTH'($urandom));
      send(v, 1'($urandom), 1'($urandom), 1);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
